// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_param
// Summary  : Parametrised up/down counter with synchronous load, count
//            enable, programmable terminal value (MAX_VAL), wrap or
//            saturate behaviour at the bounds, configurable step size,
//            a one-cycle boundary pulse and sticky overflow/underflow flags.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH     counter width in bits (2..32)
//   MAX_VAL   terminal count, legal range 0..MAX_VAL
//   STEP      amount added/subtracted per enabled cycle (1..MAX_VAL)
//   SATURATE  0 = wrap modulo MAX_VAL+1, 1 = clamp at 0 / MAX_VAL
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high, overrides everything
//   en         in   count enable
//   up         in   direction, 1 = up, 0 = down
//   load       in   synchronous load of data (clamped to MAX_VAL)
//   data       in   [WIDTH] load value
//   clr_flags  in   clear sticky ovf/unf (a same-edge boundary event wins)
//   count      out  [WIDTH] registered count
//   at_max     out  count == MAX_VAL (decoded from the register)
//   at_zero    out  count == 0 (decoded from the register)
//   wrap       out  registered pulse: previous edge hit a boundary
//   ovf        out  sticky: an up-step exceeded MAX_VAL
//   unf        out  sticky: a down-step went below 0
// ============================================================================
module updown_counter_param #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] STEP     = WIDTH'(1),
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap,
    output logic             ovf,
    output logic             unf
);

    // All arithmetic is done one bit wider than the count so that the sum
    // count+STEP and the modulus MAX_VAL+1 never overflow silently.
    localparam logic [WIDTH:0] c_MAX_EXT  = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0] c_STEP_EXT = {1'b0, STEP};
    localparam logic [WIDTH:0] c_MOD      = c_MAX_EXT + {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH:0]   w_cnt_ext;
    logic [WIDTH:0]   w_up_sum;
    logic             w_up_evt;
    logic             w_dn_evt;
    logic [WIDTH-1:0] w_up_wrapped;
    logic [WIDTH-1:0] w_dn_normal;
    logic [WIDTH-1:0] w_dn_wrapped;
    logic [WIDTH-1:0] w_load_val;

    logic [WIDTH-1:0] w_count_d;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_cnt_ext    = {1'b0, r_count};
    assign w_up_sum     = w_cnt_ext + c_STEP_EXT;
    assign w_up_evt     = (w_up_sum > c_MAX_EXT);
    assign w_dn_evt     = (w_cnt_ext < c_STEP_EXT);
    // Results below are provably < MAX_VAL+1 on the path that uses them,
    // so dropping the top bit loses nothing.
    assign w_up_wrapped = WIDTH'(w_up_sum - c_MOD);
    assign w_dn_normal  = WIDTH'(w_cnt_ext - c_STEP_EXT);
    assign w_dn_wrapped = WIDTH'(w_cnt_ext + c_MOD - c_STEP_EXT);
    assign w_load_val   = (data > MAX_VAL) ? MAX_VAL : data;

    always_comb begin
        w_count_d = r_count;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (load) begin
            w_count_d = w_load_val;
        end else if (en) begin
            if (up) begin
                if (w_up_evt) begin
                    // In saturate mode this also fires while parked at
                    // MAX_VAL, so wrap pulses every cycle up is held.
                    w_ovf_set = 1'b1;
                    w_count_d = SATURATE ? MAX_VAL : w_up_wrapped;
                end else begin
                    w_count_d = w_up_sum[WIDTH-1:0];
                end
            end else begin
                if (w_dn_evt) begin
                    w_unf_set = 1'b1;
                    w_count_d = SATURATE ? {WIDTH{1'b0}} : w_dn_wrapped;
                end else begin
                    w_count_d = w_dn_normal;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {WIDTH{1'b0}};
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_d;
            r_wrap  <= w_ovf_set | w_unf_set;
            // A new event on the same edge as clr_flags keeps the flag set.
            r_ovf   <= w_ovf_set | (r_ovf & ~clr_flags);
            r_unf   <= w_unf_set | (r_unf & ~clr_flags);
        end
    end

    assign count   = r_count;
    assign at_max  = (r_count == MAX_VAL);
    assign at_zero = (r_count == {WIDTH{1'b0}});
    assign wrap    = r_wrap;
    assign ovf     = r_ovf;
    assign unf     = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_counter_param
// Summary  : Self-checking bench for updown_counter_param. Three instances
//            cover default wrap mode, MAX_VAL=9/STEP=3 wrap mode and a
//            saturating MAX_VAL=200 counter. Stimulus pushes hand-computed
//            expectations into a queue; a monitor pops and compares one
//            edge later.
// Revision : 1.0  initial release
// ============================================================================
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [7:0] data = 8'h00;
    logic       clr_flags = 1'b0;

    logic [7:0] cnt0, cnt1, cnt2;
    logic       amx0, amx1, amx2;
    logic       azr0, azr1, azr2;
    logic       wrp0, wrp1, wrp2;
    logic       ovf0, ovf1, ovf2;
    logic       unf0, unf1, unf2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(8)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .data(data),
        .clr_flags(clr_flags), .count(cnt0), .at_max(amx0), .at_zero(azr0),
        .wrap(wrp0), .ovf(ovf0), .unf(unf0)
    );

    updown_counter_param #(.WIDTH(8), .MAX_VAL(8'd9), .STEP(8'd3), .SATURATE(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .data(data),
        .clr_flags(clr_flags), .count(cnt1), .at_max(amx1), .at_zero(azr1),
        .wrap(wrp1), .ovf(ovf1), .unf(unf1)
    );

    updown_counter_param #(.WIDTH(8), .MAX_VAL(8'd200), .STEP(8'd1), .SATURATE(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .data(data),
        .clr_flags(clr_flags), .count(cnt2), .at_max(amx2), .at_zero(azr2),
        .wrap(wrp2), .ovf(ovf2), .unf(unf2)
    );

    typedef struct {
        string      nm;
        int         d;
        logic [12:0] v;   // {count, wrap, ovf, unf, at_max, at_zero}
    } exp_t;

    exp_t q[$];

    // Push an expectation for instance d, to be compared after the next edge.
    task automatic expect_v(input string nm, input int d, input logic [7:0] c,
                            input logic w, input logic o, input logic u);
        exp_t       e;
        logic [7:0] mx;
        mx   = (d == 0) ? 8'd255 : (d == 1) ? 8'd9 : 8'd200;
        e.nm = nm;
        e.d  = d;
        e.v  = {c, w, o, u, (c == mx), (c == 8'd0)};
        q.push_back(e);
    endtask

    // Drive one cycle of inputs (on the falling edge) and record the result
    // expected for instance d after the following rising edge.
    task automatic step(input string nm, input int d, input logic r, input logic e,
                        input logic u, input logic l, input logic [7:0] dt,
                        input logic c, input logic [7:0] ec, input logic ew,
                        input logic eo, input logic eu);
        @(negedge clk);
        rst       = r;
        en        = e;
        up        = u;
        load      = l;
        data      = dt;
        clr_flags = c;
        expect_v(nm, d, ec, ew, eo, eu);
    endtask

    // Monitor: every output is registered, so each edge presents a result.
    always @(posedge clk) begin
        #1;
        while (q.size() > 0) begin
            exp_t       e;
            logic [12:0] act;
            e = q.pop_front();
            case (e.d)
                0:       act = {cnt0, wrp0, ovf0, unf0, amx0, azr0};
                1:       act = {cnt1, wrp1, ovf1, unf1, amx1, azr1};
                default: act = {cnt2, wrp2, ovf2, unf2, amx2, azr2};
            endcase
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s dut%0d: got cnt=%h wrap=%b ovf=%b unf=%b max=%b zero=%b, want cnt=%h wrap=%b ovf=%b unf=%b max=%b zero=%b",
                         e.nm, e.d, act[12:5], act[4], act[3], act[2], act[1], act[0],
                         e.v[12:5], e.v[4], e.v[3], e.v[2], e.v[1], e.v[0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset: check all three instances
        step("reset1", 0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        step("reset2", 0, 1, 1, 1, 1, 8'h77, 0, 8'h00, 0, 0, 0);
        expect_v("reset2", 1, 8'h00, 0, 0, 0);
        expect_v("reset2", 2, 8'h00, 0, 0, 0);

        // 1: load and count up
        step("t1_load", 0, 0, 0, 1, 1, 8'h2D, 0, 8'h2D, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step("t1_up", 0, 0, 1, 1, 0, 8'h00, 0, 8'(8'h2E + i), 0, 0, 0);

        // 2: wrap at top and bottom
        step("t2_load", 0, 0, 0, 1, 1, 8'hFE, 0, 8'hFE, 0, 0, 0);
        step("t2_up_max", 0, 0, 1, 1, 0, 8'h00, 0, 8'hFF, 0, 0, 0);
        step("t2_up_wrap", 0, 0, 1, 1, 0, 8'h00, 0, 8'h00, 1, 1, 0);
        step("t2_up_after", 0, 0, 1, 1, 0, 8'h00, 0, 8'h01, 0, 1, 0);
        step("t2_load0", 0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 1, 0);
        step("t2_dn_wrap", 0, 0, 1, 0, 0, 8'h00, 0, 8'hFF, 1, 1, 1);
        step("t2_hold", 0, 0, 0, 0, 0, 8'h00, 0, 8'hFF, 0, 1, 1);
        step("t2_clr", 0, 0, 0, 0, 0, 8'h00, 1, 8'hFF, 0, 0, 0);

        // 5: priority
        step("t5_rst_wins", 0, 1, 1, 1, 1, 8'h55, 0, 8'h00, 0, 0, 0);
        step("t5_load_wins", 0, 0, 1, 1, 1, 8'h10, 0, 8'h10, 0, 0, 0);
        step("t5_loadFF", 0, 0, 0, 1, 1, 8'hFF, 0, 8'hFF, 0, 0, 0);
        step("t5_clr_vs_set", 0, 0, 1, 1, 0, 8'h00, 1, 8'h00, 1, 1, 0);
        step("t5_clr_alone", 0, 0, 0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0);

        // 6: reset mid-count
        step("t6_load0", 0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0);
        step("t6_unf", 0, 0, 1, 0, 0, 8'h00, 0, 8'hFF, 1, 0, 1);
        step("t6_load40", 0, 0, 0, 1, 1, 8'h40, 0, 8'h40, 0, 0, 1);
        step("t6_up", 0, 0, 1, 1, 0, 8'h00, 0, 8'h41, 0, 0, 1);
        step("t6_rst", 0, 1, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        step("t6_resume", 0, 0, 1, 1, 0, 8'h00, 0, 8'h01, 0, 0, 0);

        // 3: MAX_VAL=9, STEP=3, wrap
        step("t3_rst", 1, 1, 0, 0, 0, 8'h00, 0, 8'd0, 0, 0, 0);
        step("t3_load8", 1, 0, 0, 1, 1, 8'd8, 0, 8'd8, 0, 0, 0);
        step("t3_up_wrap", 1, 0, 1, 1, 0, 8'd0, 0, 8'd1, 1, 1, 0);
        step("t3_load1", 1, 0, 0, 0, 1, 8'd1, 0, 8'd1, 0, 1, 0);
        step("t3_dn_wrap", 1, 0, 1, 0, 0, 8'd0, 0, 8'd8, 1, 1, 1);
        step("t3_load_clamp", 1, 0, 0, 0, 1, 8'd12, 0, 8'd9, 0, 1, 1);
        step("t3_up_from9", 1, 0, 1, 1, 0, 8'd0, 0, 8'd2, 1, 1, 1);
        step("t3_dn_from2", 1, 0, 1, 0, 0, 8'd0, 0, 8'd9, 1, 1, 1);
        step("t3_dn_normal", 1, 0, 1, 0, 0, 8'd0, 1, 8'd6, 0, 0, 0);

        // 4: saturate, MAX_VAL=200
        step("t4_rst", 2, 1, 0, 0, 0, 8'd0, 0, 8'd0, 0, 0, 0);
        step("t4_load199", 2, 0, 0, 1, 1, 8'd199, 0, 8'd199, 0, 0, 0);
        step("t4_up_max", 2, 0, 1, 1, 0, 8'd0, 0, 8'd200, 0, 0, 0);
        step("t4_up_sat1", 2, 0, 1, 1, 0, 8'd0, 0, 8'd200, 1, 1, 0);
        step("t4_up_sat2", 2, 0, 1, 1, 0, 8'd0, 0, 8'd200, 1, 1, 0);
        step("t4_load0", 2, 0, 0, 0, 1, 8'd0, 0, 8'd0, 0, 1, 0);
        step("t4_dn_sat1", 2, 0, 1, 0, 0, 8'd0, 0, 8'd0, 1, 1, 1);
        step("t4_dn_sat2", 2, 0, 1, 0, 0, 8'd0, 0, 8'd0, 1, 1, 1);
        step("t4_idle", 2, 0, 0, 0, 0, 8'd0, 0, 8'd0, 0, 1, 1);
        step("t4_load_clamp", 2, 0, 0, 0, 1, 8'd250, 0, 8'd200, 0, 1, 1);

        // Drain the scoreboard
        @(negedge clk);
        load = 1'b0;
        en   = 1'b0;
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
